alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, giving the EXEC cycles for a `MUL operation; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 SHALL have ports req0_op / req1_op  input  7  opcode (`ADD, `SUB, `MUL from CONSTANTS.vh).
REQ-006 SHALL have ports req0_x, req0_y / req1_x, req1_y  input  32  operands.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle when valid && ready.
REQ-008 SHALL have ports alu_op  output  7, alu_x  output  32, alu_y  output  32  registered drive to the shared ALU.
REQ-009 SHALL have port alu_w  input  32  ALU combinational result.
REQ-010 SHALL have ports rsp0_valid / rsp1_valid  output  1  one-cycle result strobe to requester N.
REQ-011 SHALL have port rsp_data  output  32  registered result, valid while a rspN_valid is high and held until the next capture.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-014 In IDLE, SHALL assert readyN combinationally for exactly one requester with validN high, chosen by priority; both readys low otherwise and in EXEC/RESP.
REQ-015 Priority SHALL be round-robin: when both valid, grant the requester not granted last; when one valid, grant it regardless of history.
REQ-016 On acceptance, SHALL latch op/x/y into alu_op/alu_x/alu_y, record the granted id and update last_grant, and move to EXEC.
REQ-017 On entry to EXEC, cycle counter SHALL load MUL_LAT if op == `MUL, else 1 (ADD, SUB, and any unrecognised opcode).
REQ-018 In EXEC, counter SHALL decrement each cycle; in the cycle counter == 1, rsp_data SHALL capture alu_w and FSM SHALL move to RESP.
REQ-019 In RESP, SHALL assert rspN_valid of the recorded id for exactly one cycle, then return to IDLE; no response backpressure.
REQ-020 Latency: request accepted at cycle T -> rspN_valid at T+2 for non-MUL, T+1+MUL_LAT for MUL.
REQ-021 Throughput: at most one operation in flight; next acceptance no earlier than the cycle after RESP (IDLE), i.e. T+3 for non-MUL.
REQ-022 alu_op/alu_x/alu_y SHALL hold their latched values through EXEC, RESP and IDLE until the next acceptance.
REQ-023 A request whose valid drops before acceptance SHALL be ignored; no state change.
REQ-024 Result width: rsp_data is alu_w unchanged (low 32 bits; overflow/carry not reported).

Reset
REQ-025 Reset asserted at any rising edge SHALL force IDLE, counter 0, alu_op/alu_x/alu_y/rsp_data 0, both rsp_valid 0, busy 0, last_grant = 1 (req0 wins first contention).
REQ-026 Reset during EXEC or RESP SHALL abandon the operation; no rsp_valid SHALL be emitted for it.
REQ-027 readyN SHALL be 0 in any cycle where reset is high.

Verification
REQ-028 Single ADD: req0 op=`ADD x=1 y=2 at T -> req0_ready=1 at T, rsp0_valid=1 with rsp_data=0x00000003 at T+2 only.
REQ-029 MUL latency: req1 op=`MUL x=0xFFFFFFFD y=0xFFFFFFFE, MUL_LAT=3 -> rsp1_valid at T+4, rsp_data=0x00000006, busy high T+1..T+4.
REQ-030 Contention after reset: both valid (req0 `ADD 1+2, req1 `SUB 3-2) held -> req0 served first (rsp_data 3), then req1 (rsp_data 1); then two more rounds alternate req0, req1.
REQ-031 Back-to-back single requester: req0 valid continuously with `SUB 0xFFFFFFFF-3 -> accepted every 3 cycles, each rsp_data=0xFFFFFFFC.
REQ-032 Reset mid-MUL: accept `MUL at T, assert reset at T+2 -> no rsp_valid ever for it, busy=0 and alu_x=0 at T+3, next req0 accepted at first idle cycle.
REQ-033 Overflow wrap: `ADD x=0x80000000 y=0xFFFFFFFF -> rsp_data=0x7FFFFFFF, no other flag.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight; operands and the result are held in registers.
module alu_arbiter #(
    parameter int         MUL_LAT = 3,
    parameter logic [6:0] OP_ADD  = 7'h01,
    parameter logic [6:0] OP_SUB  = 7'h02,
    parameter logic [6:0] OP_MUL  = 7'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [6:0]  req0_op,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [6:0]  req1_op,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    output logic        req1_ready,
    output logic [6:0]  alu_op,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_w,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    localparam logic [3:0] MUL_CYCLES = 4'(MUL_LAT);

    state_t      r_state;
    logic        r_last_grant;
    logic        r_id;
    logic [3:0]  r_count;
    logic [6:0]  r_alu_op;
    logic [31:0] r_alu_x;
    logic [31:0] r_alu_y;
    logic [31:0] r_rsp_data;
    logic        r_rsp0_valid;
    logic        r_rsp1_valid;
    logic        r_busy;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic [6:0]  w_op;
    logic [31:0] w_x;
    logic [31:0] w_y;

    // A lone requester always wins; under contention the one not served last wins.
    assign w_idle   = (r_state == ST_IDLE) && !reset;
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept = w_grant0 || w_grant1;

    assign w_op = w_grant1 ? req1_op : req0_op;
    assign w_x  = w_grant1 ? req1_x  : req0_x;
    assign w_y  = w_grant1 ? req1_y  : req0_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_count      <= 4'd0;
            r_alu_op     <= 7'd0;
            r_alu_x      <= 32'd0;
            r_alu_y      <= 32'd0;
            r_rsp_data   <= 32'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_op     <= w_op;
                        r_alu_x      <= w_x;
                        r_alu_y      <= w_y;
                        r_id         <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_count      <= (w_op == OP_MUL) ? MUL_CYCLES : 4'd1;
                        r_state      <= ST_EXEC;
                        r_busy       <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // Final EXEC cycle: capture the ALU result and raise the strobe for RESP.
                    if (r_count == 4'd1) begin
                        r_rsp_data   <= alu_w;
                        r_count      <= 4'd0;
                        r_rsp0_valid <= !r_id;
                        r_rsp1_valid <= r_id;
                        r_state      <= ST_RESP;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign alu_op     = r_alu_op;
    assign alu_x      = r_alu_x;
    assign alu_y      = r_alu_y;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_data   = r_rsp_data;
    assign busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: grants are matched against a directed
// expectation queue, responses against the queued result and due cycle.
module tb_alu_arbiter;

    localparam int         MUL_LAT = 3;
    localparam logic [6:0] OP_ADD  = 7'h01;
    localparam logic [6:0] OP_SUB  = 7'h02;
    localparam logic [6:0] OP_MUL  = 7'h03;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [6:0]  req0_op, req1_op;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic        req0_ready, req1_ready;
    logic [6:0]  alu_op;
    logic [31:0] alu_x, alu_y, alu_w;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic        busy;

    alu_arbiter #(
        .MUL_LAT(MUL_LAT), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB), .OP_MUL(OP_MUL)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
        .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_w(alu_w),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .busy(busy)
    );

    // The shared ALU the arbiter drives.
    always_comb begin
        alu_w = 32'd0;
        case (alu_op)
            OP_ADD:  alu_w = alu_x + alu_y;
            OP_SUB:  alu_w = alu_x - alu_y;
            OP_MUL:  alu_w = alu_x * alu_y;
            default: alu_w = 32'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit id; logic [31:0] data; int lat; } exp_t;
    typedef struct { bit id; logic [31:0] data; int due; } rsp_t;

    exp_t exp_q[$];
    rsp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   acc_cnt     = 0;
    int   last_acc    = 0;
    int   prev_acc    = 0;

    // Grant monitor: each acceptance must match the next directed expectation.
    always @(negedge clk) begin
        exp_t e;
        bit   gid;
        if ((req0_ready && req1_ready) || (req0_ready && !req0_valid) ||
            (req1_ready && !req1_valid)) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_legal cyc=%0d ready0=%0b ready1=%0b valid0=%0b valid1=%0b required one ready on a valid requester",
                     cyc, req0_ready, req1_ready, req0_valid, req1_valid);
        end else if (req0_ready || req1_ready) begin
            gid = req1_ready;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_grant cyc=%0d id=%0d required no grant", cyc, gid);
            end else begin
                e = exp_q.pop_front();
                if (gid != e.id) begin
                    miscompares++;
                    $display("FAIL grant_id cyc=%0d actual=%0d required=%0d", cyc, gid, e.id);
                end
                sb_q.push_back('{e.id, e.data, cyc + e.lat});
            end
            prev_acc = last_acc;
            last_acc = cyc;
            acc_cnt++;
        end
    end

    // Response monitor: strobe, id, data and arrival cycle against the scoreboard.
    always @(negedge clk) begin
        rsp_t r;
        if (rsp0_valid || rsp1_valid) begin
            vectors++;
            if (rsp0_valid && rsp1_valid) begin
                miscompares++;
                $display("FAIL rsp_onehot cyc=%0d both strobes high, required one", cyc);
            end else if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rsp cyc=%0d id=%0d data=%h required none", cyc, rsp1_valid, rsp_data);
            end else begin
                r = sb_q.pop_front();
                if (rsp1_valid != r.id || rsp_data !== r.data || cyc != r.due) begin
                    miscompares++;
                    $display("FAIL rsp actual id=%0d data=%h cyc=%0d required id=%0d data=%h cyc=%0d",
                             rsp1_valid, rsp_data, cyc, r.id, r.data, r.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic wait_accepts(input int n);
        int budget = 0;
        while (acc_cnt < n && budget < 60) begin
            @(posedge clk); #1;
            budget++;
        end
        if (acc_cnt < n) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout accepted=%0d required=%0d", acc_cnt, n);
        end
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((sb_q.size() > 0 || exp_q.size() > 0 || busy) && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        if (sb_q.size() > 0 || exp_q.size() > 0 || busy) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending_rsp=%0d pending_grant=%0d busy=%0b required empty/idle",
                     sb_q.size(), exp_q.size(), busy);
        end
    endtask

    task automatic set_req(input bit id, input logic [6:0] op, input logic [31:0] x, input logic [31:0] y);
        if (id) begin
            req1_op = op; req1_x = x; req1_y = y; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_x = x; req0_y = y; req0_valid = 1'b1;
        end
    endtask

    initial begin
        int t;
        int base;
        reset = 1'b1;
        req0_valid = 1'b0; req0_op = 7'd0; req0_x = 32'd0; req0_y = 32'd0;
        req1_valid = 1'b0; req1_op = 7'd0; req1_x = 32'd0; req1_y = 32'd0;

        // Single ADD, presented while reset is still high.
        exp_q.push_back('{1'b0, 32'h0000_0003, 2});
        set_req(1'b0, OP_ADD, 32'd1, 32'd2);
        @(negedge clk);
        check("ready0_in_reset", {31'd0, req0_ready}, 32'd0);
        check("busy_reset", {31'd0, busy}, 32'd0);
        check("alu_x_reset", alu_x, 32'd0);
        check("alu_op_reset", {25'd0, alu_op}, 32'd0);
        check("rsp_data_reset", rsp_data, 32'd0);
        check("rsp_valid_reset", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_accepts(1);
        req0_valid = 1'b0;
        wait_drain();

        // MUL on req1: result at T+4, busy over T+1..T+4.
        exp_q.push_back('{1'b1, 32'h0000_0006, 1 + MUL_LAT});
        set_req(1'b1, OP_MUL, 32'hFFFF_FFFD, 32'hFFFF_FFFE);
        wait_accepts(2);
        req1_valid = 1'b0;
        t = last_acc;
        while (cyc <= t + 5) begin
            @(negedge clk);
            check("busy_mul", {31'd0, busy}, 32'((cyc >= t + 1) && (cyc <= t + 4)));
        end
        wait_drain();

        // Contention after reset: req0 first, then strict alternation.
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        base = acc_cnt;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) exp_q.push_back('{1'b0, 32'h0000_0003, 2});
            else            exp_q.push_back('{1'b1, 32'h0000_0001, 2});
        end
        set_req(1'b0, OP_ADD, 32'd1, 32'd2);
        set_req(1'b1, OP_SUB, 32'd3, 32'd2);
        wait_accepts(base + 6);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();

        // Back-to-back single requester: one acceptance every 3 cycles.
        base = acc_cnt;
        for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, 32'hFFFF_FFFC, 2});
        set_req(1'b0, OP_SUB, 32'hFFFF_FFFF, 32'd3);
        for (int k = 1; k <= 4; k++) begin
            wait_accepts(base + k);
            if (k > 1) check("b2b_spacing", 32'(last_acc - prev_acc), 32'd3);
        end
        req0_valid = 1'b0;
        wait_drain();

        // Reset two cycles into a MUL: the operation is abandoned silently.
        base = acc_cnt;
        exp_q.push_back('{1'b0, 32'h0000_0006, 1 + MUL_LAT});
        set_req(1'b0, OP_MUL, 32'd2, 32'd3);
        wait_accepts(base + 1);
        req0_valid = 1'b0;
        t = last_acc;
        @(posedge clk); #1;
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back('{1'b0, 32'h0000_000B, 2});
        set_req(1'b0, OP_ADD, 32'd5, 32'd6);
        @(negedge clk);
        check("busy_after_reset", {31'd0, busy}, 32'd0);
        check("alu_x_after_reset", alu_x, 32'd0);
        wait_accepts(base + 2);
        check("accept_after_reset", 32'(last_acc), 32'(t + 3));
        req0_valid = 1'b0;
        wait_drain();

        // Overflow wraps; operands and result hold once idle.
        exp_q.push_back('{1'b1, 32'h7FFF_FFFF, 2});
        set_req(1'b1, OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_accepts(acc_cnt + 1);
        req1_valid = 1'b0;
        wait_drain();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("alu_x_hold", alu_x, 32'h8000_0000);
        check("alu_y_hold", alu_y, 32'hFFFF_FFFF);
        check("alu_op_hold", {25'd0, alu_op}, {25'd0, OP_ADD});
        check("rsp_data_hold", rsp_data, 32'h7FFF_FFFF);

        check("scoreboard_empty", 32'(sb_q.size() + exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d required bench completion", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
